// File: rtl/fft_pkg.sv
// fft_pkg: shared types and constants for the FFT front end.
//   FFT_FRAME_LEN  - words per FFT input frame
//   FFT_SAMPLE_W   - sample width in bits
//   sample_t       - one input sample
//   framer_state_t - sample_framer FSM states
package fft_pkg;
    localparam int FFT_FRAME_LEN = 48;
    localparam int FFT_SAMPLE_W  = 16;

    typedef logic [15:0] sample_t;

    typedef enum logic {FILL, HOLD} framer_state_t;
endpackage

// File: rtl/framer_fifo.sv
// framer_fifo: synchronous FIFO buffering samples ahead of the framer.
// Ports:
//   clk, n_rst    - clock, asynchronous active-low reset
//   push, wdata   - write request and data (ignored when full)
//   pop, rdata    - read request (ignored when empty); rdata shows the head word
//   full, empty   - occupancy flags decoded from the extra pointer MSB
module framer_fifo
    import fft_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    n_rst,
    input  logic    push,
    input  sample_t wdata,
    input  logic    pop,
    output sample_t rdata,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // index bits match.
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    sample_t     mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty   = (wptr_q == rptr_q);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: a word is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/sample_framer.sv
// sample_framer: feeds a 48x16 serial-to-parallel frame register.
// Samples arrive on a valid/ready handshake, are buffered in framer_fifo
// and shifted out one word per cycle. After FRAME_LEN strobes the block
// raises frame_valid and stops shifting until frame_ack.
// Optional feature macro: FRAMER_ZERO_PAD_EN (pad_req zero-fills a partial frame).
// Ports:
//   clk, n_rst                 - clock, asynchronous active-low reset
//   sample_valid/data/ready    - upstream handshake (ready = FIFO not full)
//   pad_req                    - request to zero-pad the current frame
//   frame_ack                  - downstream consumed the frame
//   it_cnt_strobe, serial_out  - registered shift strobe and word
//   frame_valid                - frame register holds a complete frame
//   word_cnt                   - words shifted into the current frame
module sample_framer
    import fft_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN  = FFT_FRAME_LEN
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        sample_ready,
    input  logic        pad_req,
    input  logic        frame_ack,
    output logic        it_cnt_strobe,
    output logic [15:0] serial_out,
    output logic        frame_valid,
    output logic [5:0]  word_cnt
);
    localparam logic [5:0] LAST_CNT = 6'(FRAME_LEN - 1);

    framer_state_t state_q, state_d;
    logic          strobe_q, strobe_d;
    sample_t       serial_q, serial_d;
    logic          fv_q, fv_d;
    logic [5:0]    cnt_q, cnt_d;

    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_pop;
    sample_t fifo_rdata;
    logic    shift;

`ifdef FRAMER_ZERO_PAD_EN
    logic pad_q, pad_d;
`else
    logic unused_pad;
    assign unused_pad = pad_req;
`endif

    assign sample_ready  = !fifo_full;
    assign it_cnt_strobe = strobe_q;
    assign serial_out    = serial_q;
    assign frame_valid   = fv_q;
    assign word_cnt      = cnt_q;

    framer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (sample_valid && !fifo_full),
        .wdata (sample_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        strobe_d = 1'b0;
        serial_d = serial_q;
        fv_d     = fv_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        shift    = 1'b0;
`ifdef FRAMER_ZERO_PAD_EN
        pad_d    = pad_q;
`endif
        case (state_q)
            FILL: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift    = 1'b1;
                    serial_d = fifo_rdata;
                end
`ifdef FRAMER_ZERO_PAD_EN
                // Real samples win; zeros only once the buffer has run dry.
                else if (pad_q) begin
                    shift    = 1'b1;
                    serial_d = '0;
                end
                if (pad_req && (cnt_q != 6'd0)) pad_d = 1'b1;
`endif
                if (shift) begin
                    strobe_d = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = 6'd0;
                        state_d = HOLD;
`ifdef FRAMER_ZERO_PAD_EN
                        pad_d   = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            HOLD: begin
                // The final strobe is still on the wire in the first HOLD
                // cycle; frame_valid follows it by one cycle.
                if (strobe_q) fv_d = 1'b1;
                if (fv_q && frame_ack) begin
                    fv_d    = 1'b0;
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= FILL;
            strobe_q <= 1'b0;
            serial_q <= '0;
            fv_q     <= 1'b0;
            cnt_q    <= 6'd0;
`ifdef FRAMER_ZERO_PAD_EN
            pad_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
            serial_q <= serial_d;
            fv_q     <= fv_d;
            cnt_q    <= cnt_d;
`ifdef FRAMER_ZERO_PAD_EN
            pad_q    <= pad_d;
`endif
        end
    end
endmodule
